cic_comb_sub: RTL and testbench

- Multichannel CIC comb stage: y[n] = x[n] - x[n-M], with up to 16 interleaved channels.
- Sits directly downstream of the integrator chain. The first instance also performs the per-channel decimation by R (HAS_DECIM=1); later instances are cascaded with HAS_DECIM=0.
- Fully synchronous to CLK; inputs are one-cycle valid strobes.

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_chan_decim_cnt.sv | 36 +++
 rtl/cic_comb_sub.sv | 96 +++++++++
 tb/tb_cic_comb_sub.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC filter blocks: config-state encoding,
// channel index width and the default datapath width.
package cic_pkg;

  localparam logic [2:0] CFG_STATE_CLEAR  = 3'd3;
  localparam int         CH_W             = 4;
  localparam int         N_SLOTS          = 1 << CH_W;
  localparam int         MIDDLE_WIDTH_DEF = 37;

  function automatic logic is_clear_state(input logic [2:0] state);
    return state == CFG_STATE_CLEAR;
  endfunction

endpackage

// File: rtl/cic_chan_decim_cnt.sv
// Per-channel decimation counter bank; keep is high when the current sample
// of channel ch survives decimation by ratio.
module cic_chan_decim_cnt
  import cic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [CH_W-1:0]  ch,
  input  logic [CNT_W-1:0] ratio,
  output logic             keep
);

  logic [CNT_W-1:0] cnt [N_SLOTS];
  logic [CNT_W-1:0] last;

  // A count already at or past ratio-1 (ratio lowered mid-run) keeps and wraps.
  always_comb begin
    last = ratio - CNT_W'(1);
    keep = (ratio < CNT_W'(2)) || (cnt[ch] >= last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_SLOTS; i++) cnt[i] <= '0;
    end else if (step) begin
      cnt[ch] <= keep ? '0 : cnt[ch] + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cic_comb_sub.sv
// Multichannel CIC comb stage y = x - x[n-M] with optional per-channel
// decimation ahead of the comb; bypasses samples when the stage is disabled.
module cic_comb_sub
  import cic_pkg::*;
#(
  parameter int MIDDLE_WIDTH          = MIDDLE_WIDTH_DEF,
  parameter int CIC_MAX_CHANNELS      = 16,
  parameter int CIC_CONFIG_DATA_WIDTH = 16,
  parameter int DIFF_DELAY            = 1,
  parameter int HAS_DECIM             = 1
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [3:0]                       idx,
  input  logic [2:0]                       state_idx_reg,
  input  logic [CIC_CONFIG_DATA_WIDTH-1:0] CIC_NUMSECS_reg,
  input  logic [CIC_CONFIG_DATA_WIDTH-1:0] CIC_DECIM_reg,
  input  logic [MIDDLE_WIDTH-1:0]          Data_In,
  input  logic                             Data_In_Valid,
  input  logic [CH_W-1:0]                  Data_In_ChIdx,
  output logic [MIDDLE_WIDTH-1:0]          Data_Out,
  output logic                             Data_Out_Valid,
  output logic [CH_W-1:0]                  Data_Out_ChIdx
);

  // Handshake: Data_In_Valid and Data_Out_Valid are single-cycle strobes with
  // no ready; every strobe is consumed and downstream must take every output.

  logic                    en, clr, ch_ok, accept, keep_raw, keep, take;
  logic [MIDDLE_WIDTH-1:0] tap, y;
  logic [MIDDLE_WIDTH-1:0] d0 [N_SLOTS];
  logic [MIDDLE_WIDTH-1:0] d1 [N_SLOTS];
  logic                    primed [N_SLOTS];

  always_comb begin
    en     = CIC_NUMSECS_reg[idx];
    clr    = is_clear_state(state_idx_reg);
    ch_ok  = 32'(Data_In_ChIdx) < CIC_MAX_CHANNELS;
    accept = Data_In_Valid && !clr && en && ch_ok;
    keep   = (HAS_DECIM == 0) || keep_raw;
    take   = accept && keep;
  end

  cic_chan_decim_cnt #(
    .CNT_W (CIC_CONFIG_DATA_WIDTH)
  ) u_decim (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (clr),
    .step  (accept && (HAS_DECIM != 0)),
    .ch    (Data_In_ChIdx),
    .ratio (CIC_DECIM_reg),
    .keep  (keep_raw)
  );

  // An unprimed channel subtracts zero; its delay line is zero anyway.
  always_comb begin
    tap = (DIFF_DELAY == 2) ? d1[Data_In_ChIdx] : d0[Data_In_ChIdx];
    y   = primed[Data_In_ChIdx] ? (Data_In - tap) : Data_In;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Data_Out       <= '0;
      Data_Out_Valid <= 1'b0;
      Data_Out_ChIdx <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        d0[i]     <= '0;
        d1[i]     <= '0;
        primed[i] <= 1'b0;
      end
    end else if (clr) begin
      Data_Out_Valid <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        d0[i]     <= '0;
        d1[i]     <= '0;
        primed[i] <= 1'b0;
      end
    end else begin
      Data_Out_Valid <= 1'b0;
      if (Data_In_Valid && !en) begin
        Data_Out       <= Data_In;
        Data_Out_Valid <= 1'b1;
        Data_Out_ChIdx <= Data_In_ChIdx;
      end else if (take) begin
        Data_Out               <= y;
        Data_Out_Valid         <= 1'b1;
        Data_Out_ChIdx         <= Data_In_ChIdx;
        d1[Data_In_ChIdx]      <= d0[Data_In_ChIdx];
        d0[Data_In_ChIdx]      <= Data_In;
        primed[Data_In_ChIdx]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_sub.sv
// Directed bench for cic_comb_sub: one M=1 and one M=2 instance share inputs.
module tb_cic_comb_sub;

  localparam int MW = 37;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [3:0]    idx;
  logic [2:0]    state_idx_reg;
  logic [15:0]   CIC_NUMSECS_reg;
  logic [15:0]   CIC_DECIM_reg;
  logic [MW-1:0] Data_In;
  logic          Data_In_Valid;
  logic [3:0]    Data_In_ChIdx;

  logic [MW-1:0] out_m1, out_m2;
  logic          vld_m1, vld_m2;
  logic [3:0]    ch_m1, ch_m2;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cic_comb_sub #(.DIFF_DELAY(1), .HAS_DECIM(1)) dut_m1 (
    .CLK(CLK), .nRST(nRST), .idx(idx), .state_idx_reg(state_idx_reg),
    .CIC_NUMSECS_reg(CIC_NUMSECS_reg), .CIC_DECIM_reg(CIC_DECIM_reg),
    .Data_In(Data_In), .Data_In_Valid(Data_In_Valid), .Data_In_ChIdx(Data_In_ChIdx),
    .Data_Out(out_m1), .Data_Out_Valid(vld_m1), .Data_Out_ChIdx(ch_m1)
  );

  cic_comb_sub #(.DIFF_DELAY(2), .HAS_DECIM(1)) dut_m2 (
    .CLK(CLK), .nRST(nRST), .idx(idx), .state_idx_reg(state_idx_reg),
    .CIC_NUMSECS_reg(CIC_NUMSECS_reg), .CIC_DECIM_reg(CIC_DECIM_reg),
    .Data_In(Data_In), .Data_In_Valid(Data_In_Valid), .Data_In_ChIdx(Data_In_ChIdx),
    .Data_Out(out_m2), .Data_Out_Valid(vld_m2), .Data_Out_ChIdx(ch_m2)
  );

  function automatic logic [63:0] w(input longint v);
    return {27'b0, v[MW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m1(input string tag, input logic v, input longint d, input logic [3:0] c);
    chk({tag, ".valid"}, 64'(vld_m1), 64'(v));
    if (v) begin
      chk({tag, ".data"}, {27'b0, out_m1}, w(d));
      chk({tag, ".ch"}, 64'(ch_m1), 64'(c));
    end
  endtask

  task automatic chk_m2(input string tag, input logic v, input longint d, input logic [3:0] c);
    chk({tag, ".valid"}, 64'(vld_m2), 64'(v));
    if (v) begin
      chk({tag, ".data"}, {27'b0, out_m2}, w(d));
      chk({tag, ".ch"}, 64'(ch_m2), 64'(c));
    end
  endtask

  // Present one input cycle and advance to just after the edge that samples it.
  task automatic step(input logic v, input longint d, input logic [3:0] c);
    Data_In_Valid = v;
    Data_In       = d[MW-1:0];
    Data_In_ChIdx = c;
    @(posedge CLK);
    #1;
    Data_In_Valid = 1'b0;
  endtask

  task automatic clear_pulse();
    state_idx_reg = 3'd3;
    step(1'b0, 0, 4'd0);
    state_idx_reg = 3'd0;
  endtask

  initial begin
    nRST = 1'b0; idx = 4'd0; state_idx_reg = 3'd0;
    CIC_NUMSECS_reg = 16'h0000; CIC_DECIM_reg = 16'd1;
    Data_In = '0; Data_In_Valid = 1'b0; Data_In_ChIdx = 4'd0;

    #12;
    chk("reset.m1.valid", 64'(vld_m1), 64'(0));
    chk("reset.m1.data", {27'b0, out_m1}, 64'(0));
    chk("reset.m1.ch", 64'(ch_m1), 64'(0));
    chk("reset.m2.valid", 64'(vld_m2), 64'(0));
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Bypass: stage disabled
    step(1'b1, 5, 4'd2);   chk_m1("byp0", 1'b1, 5, 4'd2);
    step(1'b1, -3, 4'd2);  chk_m1("byp1", 1'b1, -3, 4'd2);
    step(1'b0, 0, 4'd0);
    chk_m1("byp_idle", 1'b0, 0, 4'd0);
    chk("byp_hold.data", {27'b0, out_m1}, w(-3));

    // Comb M=1, R=1 on ch0, back-to-back same channel
    CIC_NUMSECS_reg = 16'h0001;
    step(1'b1, 10, 4'd0);  chk_m1("comb0", 1'b1, 10, 4'd0);
    step(1'b1, 15, 4'd0);  chk_m1("comb1", 1'b1, 5, 4'd0);
    step(1'b1, 15, 4'd0);  chk_m1("comb2", 1'b1, 0, 4'd0);
    step(1'b1, 7, 4'd0);   chk_m1("comb3", 1'b1, -8, 4'd0);

    // Decimation R=4 on ch1
    CIC_DECIM_reg = 16'd4;
    step(1'b1, 1, 4'd1);   chk_m1("dec1", 1'b0, 0, 4'd1);
    step(1'b1, 2, 4'd1);   chk_m1("dec2", 1'b0, 0, 4'd1);
    step(1'b1, 3, 4'd1);   chk_m1("dec3", 1'b0, 0, 4'd1);
    step(1'b1, 4, 4'd1);   chk_m1("dec4", 1'b1, 4, 4'd1);
    step(1'b1, 5, 4'd1);   chk_m1("dec5", 1'b0, 0, 4'd1);
    step(1'b1, 6, 4'd1);   chk_m1("dec6", 1'b0, 0, 4'd1);
    step(1'b1, 7, 4'd1);   chk_m1("dec7", 1'b0, 0, 4'd1);
    step(1'b1, 8, 4'd1);   chk_m1("dec8", 1'b1, 4, 4'd1);
    CIC_DECIM_reg = 16'd1;

    // Clear drops a concurrent input
    state_idx_reg = 3'd3;
    step(1'b1, 99, 4'd0);
    state_idx_reg = 3'd0;
    chk_m1("clr_drop", 1'b0, 0, 4'd0);
    chk_m2("clr_drop_m2", 1'b0, 0, 4'd0);

    // Interleaved ch0/ch3 on M=2
    step(1'b1, 100, 4'd0); chk_m2("il0", 1'b1, 100, 4'd0);
    step(1'b1, 1, 4'd3);   chk_m2("il1", 1'b1, 1, 4'd3);
    step(1'b1, 200, 4'd0); chk_m2("il2", 1'b1, 200, 4'd0);
    step(1'b1, 2, 4'd3);   chk_m2("il3", 1'b1, 2, 4'd3);
    step(1'b1, 300, 4'd0); chk_m2("il4", 1'b1, 200, 4'd0);
    step(1'b1, 3, 4'd3);   chk_m2("il5", 1'b1, 2, 4'd3);

    // Modular wrap on ch5, M=1
    step(1'b1, 1, 4'd5);             chk_m1("wrap0", 1'b1, 1, 4'd5);
    step(1'b1, -(64'sd1 << 36), 4'd5);
    chk_m1("wrap1", 1'b1, (64'sd1 << 36) - 1, 4'd5);

    // Clear mid-run on ch0
    clear_pulse();
    step(1'b1, 50, 4'd0);  chk_m1("pre_clr", 1'b1, 50, 4'd0);
    clear_pulse();
    chk_m1("clr_cycle", 1'b0, 0, 4'd0);
    step(1'b1, 20, 4'd0);  chk_m1("post_clr", 1'b1, 20, 4'd0);

    // Asynchronous reset in the middle of a strobe
    Data_In_Valid = 1'b1; Data_In = 37'd77; Data_In_ChIdx = 4'd0;
    #2;
    nRST = 1'b0;
    #1;
    chk("areset.valid", 64'(vld_m1), 64'(0));
    chk("areset.data", {27'b0, out_m1}, 64'(0));
    chk("areset.ch", 64'(ch_m1), 64'(0));
    Data_In_Valid = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    step(1'b1, 30, 4'd0);  chk_m1("post_rst", 1'b1, 30, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
